// File: rtl/if_fetch.sv
// if_fetch: PC generation and credit-limited instruction fetch over req/gnt/rvalid,
// with an in-order queue toward if_id and jump flush that drops stale responses.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d, jump_pc;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   addr_mem_q [DEPTH];
    logic [CW:0]   credit;
    logic          pop, push, grant, drop_now;

    assign jump_pc      = {jump_addr_i[31:2], 2'b00};
    assign inst_valid_o = !jump_en_i && count_q != '0;
    assign pop          = inst_valid_o && id_ready_i;
    // Doomed in-flight requests still hold a slot, so the queue can never overflow.
    assign credit       = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    assign imem_req_o   = !rst && !jump_en_i && credit < (CW + 1)'(DEPTH);
    assign imem_addr_o  = pc_q;
    assign grant        = imem_req_o && imem_gnt_i;
    assign drop_now     = drop_q != '0;
    assign push         = imem_rvalid_i && !jump_en_i && !drop_now;
    assign inst_o       = inst_valid_o ? inst_mem_q[rptr_q] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? addr_mem_q[rptr_q] : resp_pc_q;

    always_comb begin
        inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);
        drop_d     = jump_en_i ? inflight_q - CW'(imem_rvalid_i) : drop_q - CW'(imem_rvalid_i && drop_now);
        count_d    = jump_en_i ? '0 : count_q + CW'(push) - CW'(pop);
        rptr_d     = jump_en_i ? '0 : rptr_q + PW'(pop);
        wptr_d     = jump_en_i ? '0 : wptr_q + PW'(push);
        pc_d       = jump_en_i ? jump_pc : pc_q + (grant ? 32'd4 : 32'd0);
        resp_pc_d  = jump_en_i ? jump_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wptr_q] <= imem_rdata_i;
            addr_mem_q[wptr_q] <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed table plus hand sequences against a bench-side memory that returns addr as data.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, jump_en_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic        inst_valid_o, id_ready_i;
    logic [31:0] jump_addr_i, imem_addr_o, imem_rdata_i, inst_o, inst_addr_o;

    if_fetch dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct packed {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ia;
    } vec_t;

    pend_t       pend[$];
    vec_t        tbl[13];
    int          checks = 0, failures = 0, cyc = 0, lat = 1, pops = 0;
    bit          rand_gnt = 0, rand_lat = 0, prev_hold;
    logic        s_req, s_gnt, s_valid;
    logic [31:0] s_addr, s_inst, s_iaddr, exp_next, prev_addr;
    logic [1:0]  s_drop;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        pend_t e;
        imem_gnt_i = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
        imem_rvalid_i = pend.size() > 0 && pend[0].due <= cyc;
        imem_rdata_i = imem_rvalid_i ? pend[0].addr : 32'hDEAD_BEEF;
        @(negedge clk);
        s_req = imem_req_o; s_gnt = imem_gnt_i; s_addr = imem_addr_o;
        s_valid = inst_valid_o; s_inst = inst_o; s_iaddr = inst_addr_o; s_drop = dut.drop_q;
        chk("no_push_when_full", 32'(imem_rvalid_i && dut.count_q == 2'd2), 0);
        chk("drop_le_inflight", 32'(dut.drop_q <= dut.inflight_q), 1);
        if (imem_rvalid_i) void'(pend.pop_front());
        if (s_req && s_gnt) begin
            e.addr = s_addr;
            e.due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat);
            pend.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_cyc(input string tag, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] ia);
        chk({tag, "_req"}, 32'(s_req), 32'(req));
        chk({tag, "_addr"}, s_addr, addr);
        chk({tag, "_valid"}, 32'(s_valid), 32'(vld));
        chk({tag, "_inst"}, s_inst, vld ? ia : NOP);
        if (vld) chk({tag, "_iaddr"}, s_iaddr, ia);
    endtask

    task automatic do_reset();
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        pend.delete();
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0; lat = 1;
    endtask

    task automatic jstep(input logic j, input logic [31:0] ja);
        jump_en_i = j; jump_addr_i = ja;
        step();
        jump_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = '0; id_ready_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        #2;
        chk("rst_req", 32'(imem_req_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'h0);

        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[10] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            id_ready_i = tbl[i].rdy;
            step();
            expect_cyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ia);
        end

        // Two requests in flight at the jump; both responses must be dropped.
        id_ready_i = 1'b1; lat = 3;
        step();                         expect_cyc("j1_c13", 1, 32'h20, 1, 32'h18);
        step();                         expect_cyc("j1_c14", 1, 32'h24, 1, 32'h1C);
        jstep(1, 32'h0000_0102);        expect_cyc("j1_jump", 0, 32'h28, 0, 0);
        lat = 1;
        step();                         expect_cyc("j1_c16", 0, 32'h100, 0, 0);
        step();                         expect_cyc("j1_c17", 1, 32'h100, 0, 0);
        step();                         expect_cyc("j1_c18", 1, 32'h104, 0, 0);
        step();                         expect_cyc("j1_c19", 1, 32'h108, 1, 32'h100);
        // Jump with a valid head and a response landing in the same cycle.
        jstep(1, 32'h0000_0300);        expect_cyc("j2_jump", 0, 32'h10C, 0, 0);
        step();                         expect_cyc("j2_c21", 1, 32'h300, 0, 0);
        step();                         expect_cyc("j2_c22", 1, 32'h304, 0, 0);
        step();                         expect_cyc("j2_c23", 1, 32'h308, 1, 32'h300);

        // Back-to-back style jumps with a 2-cycle memory.
        do_reset();
        lat = 2;
        step();                         expect_cyc("bb_c0", 1, 32'h0, 0, 0);
        step();                         expect_cyc("bb_c1", 1, 32'h4, 0, 0);
        jstep(1, 32'h0000_0180);        expect_cyc("bb_c2", 0, 32'h8, 0, 0);
        step();                         expect_cyc("bb_c3", 1, 32'h180, 0, 0);
        chk("bb_c3_drop", 32'(s_drop), 1);
        jstep(1, 32'h0000_0200);        expect_cyc("bb_c4", 0, 32'h184, 0, 0);
        chk("bb_c4_drop", 32'(s_drop), 0);
        step();                         expect_cyc("bb_c5", 1, 32'h200, 0, 0);
        chk("bb_c5_drop", 32'(s_drop), 1);
        step();                         expect_cyc("bb_c6", 1, 32'h204, 0, 0);
        chk("bb_c6_drop", 32'(s_drop), 0);
        step();                         expect_cyc("bb_c7", 0, 32'h208, 0, 0);
        step();                         expect_cyc("bb_c8", 1, 32'h208, 1, 32'h200);
        step();                         expect_cyc("bb_c9", 1, 32'h20C, 1, 32'h204);

        // Random grant, latency and ready: address stability and sequential stream.
        do_reset();
        rand_gnt = 1; rand_lat = 1; exp_next = 32'h0; prev_hold = 0;
        for (int i = 0; i < 300; i++) begin
            id_ready_i = $urandom_range(0, 3) != 0;
            step();
            if (prev_hold) chk("rand_addr_stable", s_addr, prev_addr);
            prev_hold = s_req && !s_gnt;
            prev_addr = s_addr;
            if (s_valid && id_ready_i) begin
                chk("rand_iaddr", s_iaddr, exp_next);
                chk("rand_inst", s_inst, exp_next);
                exp_next += 4;
                pops++;
            end
        end
        chk("rand_progress", 32'(pops > 50), 1);
        rand_gnt = 0; rand_lat = 0;

        // PC wrap-around, then reset asserted mid-stream.
        do_reset();
        id_ready_i = 1'b1;
        jstep(1, 32'hFFFF_FFF9);        expect_cyc("wr_c0", 0, 32'h0, 0, 0);
        step();                         expect_cyc("wr_c1", 1, 32'hFFFF_FFF8, 0, 0);
        step();                         expect_cyc("wr_c2", 1, 32'hFFFF_FFFC, 0, 0);
        step();                         expect_cyc("wr_c3", 1, 32'h0, 1, 32'hFFFF_FFF8);
        step();                         expect_cyc("wr_c4", 1, 32'h4, 1, 32'hFFFF_FFFC);
        step();                         expect_cyc("wr_c5", 1, 32'h8, 1, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req_o), 0);
        chk("mid_rst_valid", 32'(inst_valid_o), 0);
        chk("mid_rst_inst", inst_o, NOP);
        chk("mid_rst_iaddr", inst_addr_o, 32'h0);
        chk("mid_rst_addr", imem_addr_o, 32'h0);
        do_reset();
        step();                         expect_cyc("post_rst", 1, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
